// File: rtl/hdmi_video_pkg.sv
// Shared definitions for the 640x480 parallel-video receive path.
// Contents:
//   H_ACTIVE/V_ACTIVE/H_TOTAL/V_TOTAL  nominal 640x480 (800x525 total) timing
//   cap_state_t                        capture FSM states (IDLE/ARMED/CAPTURE)
//   rgb888_to_444()                    keeps the top nibble of each colour channel
package hdmi_video_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    // RGB888 {R[23:16],G[15:8],B[7:0]} -> RGB444 {R[23:20],G[15:12],B[7:4]}
    function automatic logic [11:0] rgb888_to_444(input logic [23:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

endpackage

// File: rtl/hdmi_sync_edge.sv
// Input register stage and sync/DE edge detector for the capture block.
// Every input is registered once (stage 1); the control bits are registered
// a second time (stage 2) and edges are stage-1 vs stage-2 comparisons.
// Ports:
//   clk, rst          pixel clock, async active-high reset
//   data_in           RGB888 pixel           -> data    (stage 1)
//   vsync_in          active-low VSync       -> vs_fall (frame start)
//   hsync_in          active-low HSync       -> hs_fall
//   de_in             active-video enable    -> de (stage 1), de_fall
module hdmi_sync_edge (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] data_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        de_in,
    output logic [23:0] data,
    output logic        de,
    output logic        vs_fall,
    output logic        hs_fall,
    output logic        de_fall
);

    logic vs1, hs1, vs2, hs2, de2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            de   <= 1'b0;
            vs1  <= 1'b0;
            hs1  <= 1'b0;
            vs2  <= 1'b0;
            hs2  <= 1'b0;
            de2  <= 1'b0;
        end else begin
            data <= data_in;
            de   <= de_in;
            vs1  <= vsync_in;
            hs1  <= hsync_in;
            vs2  <= vs1;
            hs2  <= hs1;
            de2  <= de;
        end
    end

    assign vs_fall = ~vs1 & vs2;
    assign hs_fall = ~hs1 & hs2;
    assign de_fall = ~de  & de2;

endmodule

// File: rtl/hdmi_frame_capture.sv
// Captures one 640x480 frame at a time from the parallel video interface into
// a linear RGB444 frame memory and checks the incoming geometry.
// Ports:
//   clk, rst                         pixel clock, async active-high reset
//   In_pData/In_pVSync/In_pHSync/In_pVDE  video input (RGB888, active-low syncs)
//   cap_en                           1 = capture continuously, 0 = stop after frame
//   Mem_Write/Mem_Write_Add/Mem_Wdata    frame-memory write port (2 clk latency)
//   frame_done                       pulse one clk after the last write of a frame
//   locked / err                     last frame clean / sticky geometry error
//   Deb_pix_count / Deb_line_count   last line length / last frame line count
// Build option: HDMI_CAP_HALF_RES_EN stores only even pixels of even lines
// (2:1 both axes); geometry checks still use the full active size.
module hdmi_frame_capture #(
    parameter int H_ACTIVE = hdmi_video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = hdmi_video_pkg::V_ACTIVE,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [23:0]       In_pData,
    input  logic              In_pVSync,
    input  logic              In_pHSync,
    input  logic              In_pVDE,
    input  logic              cap_en,
    output logic              Mem_Write,
    output logic [ADDR_W-1:0] Mem_Write_Add,
    output logic [PIX_W-1:0]  Mem_Wdata,
    output logic              frame_done,
    output logic              locked,
    output logic              err,
    output logic [15:0]       Deb_pix_count,
    output logic [15:0]       Deb_line_count
);
    import hdmi_video_pkg::*;

`ifdef HDMI_CAP_HALF_RES_EN
    localparam int PIX_TOTAL = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
    localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [23:0] pdata;
    logic        de, vs_fall, hs_fall, de_fall;

    hdmi_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .data_in  (In_pData),
        .vsync_in (In_pVSync),
        .hsync_in (In_pHSync),
        .de_in    (In_pVDE),
        .data     (pdata),
        .de       (de),
        .vs_fall  (vs_fall),
        .hs_fall  (hs_fall),
        .de_fall  (de_fall)
    );

    cap_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       pix_cnt, line_cnt;
    logic              frame_bad;     // a line/overflow error happened this frame
    logic              keep, line_bad, frame_complete, want_wr;

`ifdef HDMI_CAP_HALF_RES_EN
    assign keep = ~pix_cnt[0] & ~line_cnt[0];
`else
    assign keep = 1'b1;
`endif

    assign line_bad       = (pix_cnt != 16'(H_ACTIVE));
    // line_cnt stays at V_ACTIVE between frame end and the next frame start
    assign frame_complete = (line_cnt >= 16'(V_ACTIVE));
    assign want_wr        = (state == CAPTURE) && !frame_complete && de && keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            addr           <= '0;
            pix_cnt        <= '0;
            line_cnt       <= '0;
            frame_bad      <= 1'b0;
            Mem_Write      <= 1'b0;
            Mem_Write_Add  <= '0;
            Mem_Wdata      <= '0;
            frame_done     <= 1'b0;
            locked         <= 1'b0;
            err            <= 1'b0;
            Deb_pix_count  <= '0;
            Deb_line_count <= '0;
        end else begin
            Mem_Write  <= 1'b0;
            frame_done <= 1'b0;

            // HSync also restarts the count so a line without DE starts clean
            if (de_fall || hs_fall) pix_cnt <= '0;
            else if (de)            pix_cnt <= sat_inc(pix_cnt);
            if (de_fall) Deb_pix_count <= pix_cnt;

            if (want_wr) begin
                if (addr <= LAST_ADDR) begin
                    Mem_Write     <= 1'b1;
                    Mem_Write_Add <= addr;
                    Mem_Wdata     <= PIX_W'(rgb888_to_444(pdata));
                    addr          <= addr + 1'b1;
                end else begin
                    // address holds; the pixel is dropped
                    err       <= 1'b1;
                    locked    <= 1'b0;
                    frame_bad <= 1'b1;
                end
            end

            // Frame-start clears below come after the write so a write in the
            // FS cycle still completes and the address restarts next cycle.
            case (state)
                IDLE: if (cap_en) state <= ARMED;
                ARMED: begin
                    if (!cap_en) state <= IDLE;
                    else if (vs_fall) begin
                        state     <= CAPTURE;
                        addr      <= '0;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (vs_fall) begin
                        if (!frame_complete) begin
                            Deb_line_count <= line_cnt;
                            err            <= 1'b1;
                            locked         <= 1'b0;
                        end
                        addr      <= '0;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                        frame_bad <= 1'b0;
                    end else if (de_fall) begin
                        if (frame_complete) begin
                            // active line after the frame already ended
                            err    <= 1'b1;
                            locked <= 1'b0;
                        end else begin
                            line_cnt <= sat_inc(line_cnt);
                            if (line_bad) begin
                                err       <= 1'b1;
                                locked    <= 1'b0;
                                frame_bad <= 1'b1;
                            end
                            if (sat_inc(line_cnt) == 16'(V_ACTIVE)) begin
                                Deb_line_count <= 16'(V_ACTIVE);
                                frame_done     <= 1'b1;
                                if (!frame_bad && !line_bad) locked <= 1'b1;
                                if (!cap_en) state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (!cap_en) err <= 1'b0;
        end
    end

endmodule
